// File: rtl/spi_slave_gen_if.sv
// rtl/spi_slave_gen_if.sv - pin and memory-handshake bundle for spi_slave_gen
interface spi_slave_gen_if #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
);
    localparam int FRAME_W = CMD_W + DATA_W;

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic               tx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_ack;
    logic               frame_err;
    logic               busy;

    modport slave (
        input  SS_n, MOSI, tx_valid, tx_data,
        output MISO, rx_data, rx_valid, tx_ack, frame_err, busy
    );

    modport master (
        output SS_n, MOSI, tx_valid, tx_data,
        input  MISO, rx_data, rx_valid, tx_ack, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_gen.sv
// rtl/spi_slave_gen.sv - clk-sampled SPI slave: frame receive, read-data handshake and MISO read-out
module spi_slave_gen #(
    parameter int                DATA_W    = 8,
    parameter int                CMD_W     = 2,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [CMD_W-1:0]  READ_CMD  = {CMD_W{1'b1}}
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_gen_if.slave  bus
);
    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHIFT_IN  = 3'd1;
    localparam logic [2:0] S_WAIT_TX   = 3'd2;
    localparam logic [2:0] S_SHIFT_OUT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [FRAME_W-1:0] r_rx_shift;
    logic [FRAME_W-1:0] r_rx_data;
    logic [DATA_W-1:0]  r_tx_shift;
    logic               r_rx_valid;
    logic               r_tx_ack;
    logic               r_frame_err;
    logic               r_miso;
    logic               r_busy;

    logic [2:0]         w_next;
    logic [CNT_W-1:0]   w_bit_pos;
    logic [FRAME_W-1:0] w_frame;
    logic               w_tx_first;
    logic               w_tx_next;

    // Frame including the bit being sampled this edge, so the last bit can be decoded without a lag cycle
    always_comb begin
        w_bit_pos          = MSB_FIRST ? (LAST_IN - r_cnt) : r_cnt;
        w_frame            = r_rx_shift;
        w_frame[w_bit_pos] = bus.MOSI;
    end

    assign w_tx_first = MSB_FIRST ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
    assign w_tx_next  = MSB_FIRST ? r_tx_shift[DATA_W-1]  : r_tx_shift[0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!bus.SS_n) w_next = S_SHIFT_IN;
            S_SHIFT_IN: begin
                if (bus.SS_n)
                    w_next = S_IDLE;
                else if (r_cnt == LAST_IN)
                    w_next = (w_frame[FRAME_W-1:DATA_W] == READ_CMD) ? S_WAIT_TX : S_DONE;
            end
            S_WAIT_TX: begin
                if (bus.SS_n)          w_next = S_IDLE;
                else if (bus.tx_valid) w_next = S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                if (bus.SS_n)                w_next = S_IDLE;
                else if (r_cnt == LAST_OUT)  w_next = S_DONE;
            end
            S_DONE:      if (bus.SS_n) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Pulses and MISO default low every edge; only the active branch below raises them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_tx_shift  <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_ack    <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != S_IDLE);
            r_rx_valid  <= 1'b0;
            r_tx_ack    <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.SS_n) begin
                        r_cnt      <= '0;
                        r_rx_shift <= '0;
                    end
                end
                S_SHIFT_IN: begin
                    if (bus.SS_n) begin
                        r_frame_err <= 1'b1;
                    end else begin
                        r_rx_shift <= w_frame;
                        r_cnt      <= r_cnt + 1'b1;
                        if (r_cnt == LAST_IN) begin
                            r_rx_data  <= w_frame;
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT_TX: begin
                    if (bus.SS_n) begin
                        r_frame_err <= 1'b1;
                    end else if (bus.tx_valid) begin
                        r_tx_ack   <= 1'b1;
                        r_miso     <= w_tx_first;
                        r_tx_shift <= MSB_FIRST ? (bus.tx_data << 1) : (bus.tx_data >> 1);
                        r_cnt      <= '0;
                    end
                end
                S_SHIFT_OUT: begin
                    if (bus.SS_n) begin
                        r_frame_err <= 1'b1;
                    end else if (r_cnt != LAST_OUT) begin
                        r_miso     <= w_tx_next;
                        r_tx_shift <= MSB_FIRST ? (r_tx_shift << 1) : (r_tx_shift >> 1);
                        r_cnt      <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.MISO      = r_miso;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.tx_ack    = r_tx_ack;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_spi_slave_gen.sv
// tb/tb_spi_slave_gen.sv - MSB-first and LSB-first instances driven in lockstep against a queue scoreboard
module tb_spi_slave_gen;
    logic clk;
    logic rst_n;

    spi_slave_gen_if #(.DATA_W(8), .CMD_W(2)) if_m ();
    spi_slave_gen_if #(.DATA_W(8), .CMD_W(2)) if_l ();

    spi_slave_gen #(.DATA_W(8), .CMD_W(2), .MSB_FIRST(1'b1)) u_dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m)
    );

    spi_slave_gen #(.DATA_W(8), .CMD_W(2), .MSB_FIRST(1'b0)) u_dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_err;
    logic [9:0] q_rx[$];
    logic       q_miso_m[$];
    logic       q_miso_l[$];
    logic [9:0] last_rx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ss(input logic v);
        if_m.SS_n = v;
        if_l.SS_n = v;
    endtask

    task automatic set_tx(input logic v, input logic [7:0] d);
        if_m.tx_valid = v;
        if_l.tx_valid = v;
        if_m.tx_data  = d;
        if_l.tx_data  = d;
    endtask

    task automatic drive_bit(input logic [9:0] f, input int i);
        if_m.MOSI = f[9-i];
        if_l.MOSI = f[i];
    endtask

    task automatic chk_both(input string tag, input logic [31:0] obs_m, input logic [31:0] obs_l,
                            input logic [31:0] exp);
        chk({tag, "_m"}, obs_m, exp);
        chk({tag, "_l"}, obs_l, exp);
    endtask

    task automatic chk_idle_outs(input string tag, input logic exp_busy);
        chk_both({tag, "_miso"}, if_m.MISO, if_l.MISO, 0);
        chk_both({tag, "_txack"}, if_m.tx_ack, if_l.tx_ack, 0);
        chk_both({tag, "_busy"}, if_m.busy, if_l.busy, exp_busy);
    endtask

    task automatic chk_miso(input string tag);
        logic em, el;
        if (q_miso_m.size() == 0 || q_miso_l.size() == 0) begin
            chk({tag, "_sb_empty"}, q_miso_m.size(), 1);
        end else begin
            em = q_miso_m.pop_front();
            el = q_miso_l.pop_front();
            chk({tag, "_m"}, if_m.MISO, em);
            chk({tag, "_l"}, if_l.MISO, el);
        end
    endtask

    // Full frame; returns one cycle after the rx_valid cycle
    task automatic send_frame(input logic [9:0] f);
        logic [9:0] e;
        q_rx.push_back(f);
        set_ss(1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive_bit(f, i);
            step();
            if (i < 9) chk_both("rxv_early", if_m.rx_valid, if_l.rx_valid, 0);
        end
        e = q_rx.pop_front();
        chk_both("rxv", if_m.rx_valid, if_l.rx_valid, 1);
        chk_both("rxdata", if_m.rx_data, if_l.rx_data, e);
        chk_both("ferr_frame", if_m.frame_err, if_l.frame_err, 0);
        last_rx = e;
        step();
        chk_both("rxv_pulse", if_m.rx_valid, if_l.rx_valid, 0);
    endtask

    // tx handshake then nbits of read-out checked against the scoreboard
    task automatic read_word(input logic [7:0] d, input int nbits);
        for (int i = 0; i < 8; i++) begin
            q_miso_m.push_back(d[7-i]);
            q_miso_l.push_back(d[i]);
        end
        set_tx(1'b1, d);
        step();
        set_tx(1'b0, 8'h00);
        chk_both("txack", if_m.tx_ack, if_l.tx_ack, 1);
        chk_miso("miso_b0");
        for (int k = 1; k < nbits; k++) begin
            step();
            chk_both("txack_pulse", if_m.tx_ack, if_l.tx_ack, 0);
            chk_miso("miso_bit");
        end
    endtask

    task automatic end_frame_ok();
        set_ss(1'b1);
        step();
        chk_both("busy_end", if_m.busy, if_l.busy, 0);
        chk_both("ferr_end", if_m.frame_err, if_l.frame_err, 0);
        chk_both("miso_end", if_m.MISO, if_l.MISO, 0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        last_rx = '0;
        rst_n   = 1'b0;
        set_ss(1'b1);
        if_m.MOSI = 1'b0;
        if_l.MOSI = 1'b0;
        set_tx(1'b0, 8'h00);
        #12;
        chk_idle_outs("rst", 1'b0);
        chk_both("rst_rxv", if_m.rx_valid, if_l.rx_valid, 0);
        chk_both("rst_rxdata", if_m.rx_data, if_l.rx_data, 0);
        chk_both("rst_ferr", if_m.frame_err, if_l.frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // write frame, MSB-first and bit-reversed stream both yield 0A5
        send_frame(10'h0A5);
        chk_idle_outs("wr_done", 1'b1);
        end_frame_ok();

        // read 3C, tx_valid two cycles after rx_valid
        send_frame(10'h300);
        chk_idle_outs("rd_wait", 1'b1);
        step();
        chk_idle_outs("rd_wait2", 1'b1);
        read_word(8'h3C, 8);
        step();
        chk_idle_outs("rd_after", 1'b1);
        end_frame_ok();

        // asymmetric word separates the two bit orders
        send_frame(10'h3C4);
        read_word(8'hA1, 8);
        step();
        chk_idle_outs("rd2_after", 1'b1);
        end_frame_ok();

        // abort after 5 bits
        set_ss(1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive_bit(10'h2AA, i);
            step();
        end
        set_ss(1'b1);
        step();
        chk_both("abort_ferr", if_m.frame_err, if_l.frame_err, 1);
        chk_both("abort_rxv", if_m.rx_valid, if_l.rx_valid, 0);
        chk_both("abort_rxdata", if_m.rx_data, if_l.rx_data, last_rx);
        chk_idle_outs("abort", 1'b0);
        step();
        chk_both("abort_ferr_pulse", if_m.frame_err, if_l.frame_err, 0);
        send_frame(10'h1F0);
        end_frame_ok();

        // SS_n rising together with the last bit is an abort
        set_ss(1'b0);
        step();
        for (int i = 0; i < 9; i++) begin
            drive_bit(10'h155, i);
            step();
        end
        drive_bit(10'h155, 9);
        set_ss(1'b1);
        step();
        chk_both("lastbit_ferr", if_m.frame_err, if_l.frame_err, 1);
        chk_both("lastbit_rxv", if_m.rx_valid, if_l.rx_valid, 0);
        chk_both("lastbit_rxdata", if_m.rx_data, if_l.rx_data, 10'h1F0);
        step();

        // non-read command with tx_valid held high
        set_tx(1'b1, 8'hFF);
        send_frame(10'h2C3);
        for (int k = 0; k < 3; k++) begin
            chk_idle_outs("nonread", 1'b1);
            step();
        end
        end_frame_ok();
        set_tx(1'b0, 8'h00);

        // SS_n rising together with tx_valid is an abort
        send_frame(10'h3FF);
        step();
        set_tx(1'b1, 8'h5A);
        set_ss(1'b1);
        step();
        set_tx(1'b0, 8'h00);
        chk_both("wait_abort_ferr", if_m.frame_err, if_l.frame_err, 1);
        chk_idle_outs("wait_abort", 1'b0);
        step();

        // async reset during read-out bit 4
        send_frame(10'h3C3);
        read_word(8'h3C, 5);
        chk_both("pre_rst_miso", if_m.MISO, if_l.MISO, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outs("async_rst", 1'b0);
        chk_both("async_rst_rxdata", if_m.rx_data, if_l.rx_data, 0);
        q_miso_m.delete();
        q_miso_l.delete();
        set_ss(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send_frame(10'h0A5);
        chk_idle_outs("post_rst", 1'b1);
        end_frame_ok();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
